// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer: the reset PC default,
// the entry stored in the fetch buffer and the sequencer state encoding.
package if_fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } fetch_entry_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory port, redirect request and the
// valid/ready stream of fetched entries toward decode.
interface if_fetch_ctrl_if;

   logic [31:0] im_addr;
   logic [31:0] im_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_exc;

   // Fetch sequencer side.
   modport master (
      output im_addr,
      input  im_data,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output out_exc
   );

   // Memory / decode / redirect source side.
   modport slave (
      input  im_addr,
      output im_data,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  out_exc
   );

endinterface

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// Circular fetch buffer. Flush wins over push/pop and rewinds both pointers.
// Storage carries no reset; the head output is forced to zero while empty
// so the visible outputs are clean straight out of reset.
module fetch_fifo
   import if_fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fetch_entry_t           push_entry,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output logic                   head_valid,
   output fetch_entry_t           head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   // Next-state for pointers, occupancy and storage.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      pop_ok   = pop && (count_q != '0);
      push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage, data only.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count      = count_q;
   assign head_valid = (count_q != '0);
   assign head       = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational
// instruction memory and queues {pc, instr, exc} entries toward decode.
// A fetch from an illegal address is queued once as an exception entry
// with a zero instruction, after which fetching stops until a redirect.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          IM_WORDS = 4096,
   parameter int          DEPTH    = 2
) (
   input  logic           clk,
   input  logic           reset,
   if_fetch_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

   // Illegal fetch: misaligned or outside the instruction memory window.
   function automatic logic is_fault(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc > LAST_PC);
   endfunction

   logic [31:0]      pc_q, pc_d;
   fetch_state_t     state_q, state_d;
   logic [CNT_W-1:0] fifo_count;
   logic             head_valid;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic             push;
   logic             pop;
   logic             flush;
   logic             fetch_fault;

   // Fetch decision: redirect first, then push when the buffer has room.
   always_comb begin
      pop         = head_valid && bus.out_ready;
      fetch_fault = is_fault(pc_q);
      push_entry  = '{pc: pc_q, instr: (fetch_fault ? 32'd0 : bus.im_data), exc: fetch_fault};
      push        = 1'b0;
      flush       = 1'b0;
      pc_d        = pc_q;
      state_d     = state_q;
      if (bus.redirect_valid) begin
         flush   = 1'b1;
         pc_d    = bus.redirect_pc;
         state_d = ST_RUN;
      end else if ((state_q == ST_RUN) && ((fifo_count != FULL_CNT) || pop)) begin
         push = 1'b1;
         if (fetch_fault) begin
            state_d = ST_HALT;
         end else begin
            pc_d = pc_q + 32'd4;
         end
      end
   end

   // PC and sequencer state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         state_q <= ST_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .count      (fifo_count),
      .head_valid (head_valid),
      .head       (head)
   );

   assign bus.im_addr   = pc_q;
   assign bus.out_valid = head_valid;
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;
   assign bus.out_exc   = head.exc;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a synthetic instruction memory, a queue of
// expected entries filled as stimulus is applied, and one task per scenario.
module tb_if_fetch_ctrl;
   import if_fetch_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   fetch_entry_t exp_q[$];

   if_fetch_ctrl_if bus ();

   if_fetch_ctrl #(
      .RESET_PC (32'h0000_3000),
      .IM_WORDS (4096),
      .DEPTH    (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
   endfunction

   function automatic fetch_entry_t exp_entry(input logic [31:0] pc);
      fetch_entry_t e;
      logic bad;
      bad = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
      e.pc    = pc;
      e.exc   = bad;
      e.instr = bad ? 32'd0 : mem_word(pc);
      return e;
   endfunction

   assign bus.im_data = mem_word(bus.im_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sample the head at the falling edge, then advance one full cycle.
   task automatic step(output bit fired, output fetch_entry_t act);
      fired = bus.out_valid && bus.out_ready;
      act   = {bus.out_pc, bus.out_instr, bus.out_exc};
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic sb_pop(output fetch_entry_t e, output bit ok);
      ok = (exp_q.size() != 0);
      e  = ok ? exp_q.pop_front() : '0;
   endtask

   task automatic do_reset();
      bit fired;
      fetch_entry_t act;
      reset = 1'b1;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      step(fired, act);
      step(fired, act);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      bit fired, ok;
      fetch_entry_t act, exp;
      reset = 1'b1;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      step(fired, act);
      step(fired, act);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'd0 || bus.out_instr !== 32'd0 || bus.out_exc !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got valid=%b pc=%h instr=%h exc=%b, want all zero",
                  bus.out_valid, bus.out_pc, bus.out_instr, bus.out_exc);
      end
      n_cmp++;
      if (bus.im_addr !== 32'h0000_3000) begin
         n_bad++;
         $display("FAIL reset_pc: got %h want 00003000", bus.im_addr);
      end
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(exp_entry(32'h3000 + 32'(4 * i)));
      bus.out_ready = 1'b1;
      step(fired, act);
      for (int i = 0; i < 4; i++) begin
         step(fired, act);
         n_cmp++;
         if (!fired) begin
            n_bad++;
            $display("FAIL reset_stream_gap: cycle %0d got no transfer, want one", i);
         end else begin
            sb_pop(exp, ok);
            if (!ok || act !== exp) begin
               n_bad++;
               $display("FAIL reset_stream: got pc=%h instr=%h exc=%b, want pc=%h instr=%h exc=%b",
                        act.pc, act.instr, act.exc, exp.pc, exp.instr, exp.exc);
            end
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit fired, ok;
      fetch_entry_t act, exp;
      do_reset();
      for (int i = 0; i < 5; i++) step(fired, act);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.im_addr !== 32'h0000_3008) begin
         n_bad++;
         $display("FAIL stall_hold: got valid=%b im_addr=%h, want valid=1 im_addr=00003008",
                  bus.out_valid, bus.im_addr);
      end
      for (int i = 0; i < 3; i++) exp_q.push_back(exp_entry(32'h3000 + 32'(4 * i)));
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(fired, act);
         n_cmp++;
         if (!fired) begin
            n_bad++;
            $display("FAIL stall_drain_gap: cycle %0d got no transfer, want one", i);
         end else begin
            sb_pop(exp, ok);
            if (!ok || act !== exp) begin
               n_bad++;
               $display("FAIL stall_drain: got pc=%h instr=%h exc=%b, want pc=%h instr=%h exc=%b",
                        act.pc, act.instr, act.exc, exp.pc, exp.instr, exp.exc);
            end
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_redirect_flush();
      bit fired, ok;
      fetch_entry_t act, exp;
      do_reset();
      exp_q.push_back(exp_entry(32'h3000));
      exp_q.push_back(exp_entry(32'h3004));
      for (int i = 0; i < 3; i++) step(fired, act);
      // Redirect while full; the head handshake in this cycle still delivers.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_3040;
      bus.out_ready = 1'b1;
      step(fired, act);
      bus.redirect_valid = 1'b0;
      n_cmp++;
      sb_pop(exp, ok);
      if (!fired || !ok || act !== exp) begin
         n_bad++;
         $display("FAIL redirect_same_cycle_pop: got fired=%b pc=%h, want fired=1 pc=%h",
                  fired, act.pc, exp.pc);
      end
      exp_q.delete();
      exp_q.push_back(exp_entry(32'h3040));
      exp_q.push_back(exp_entry(32'h3044));
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL redirect_bubble: got out_valid=%b want 0", bus.out_valid);
      end
      step(fired, act);
      for (int i = 0; i < 2; i++) begin
         step(fired, act);
         n_cmp++;
         if (!fired) begin
            n_bad++;
            $display("FAIL redirect_stream_gap: cycle %0d got no transfer, want one", i);
         end else begin
            sb_pop(exp, ok);
            if (!ok || act !== exp) begin
               n_bad++;
               $display("FAIL redirect_stream: got pc=%h instr=%h exc=%b, want pc=%h instr=%h exc=%b",
                        act.pc, act.instr, act.exc, exp.pc, exp.instr, exp.exc);
            end
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_misaligned();
      bit fired, ok;
      int fires;
      fetch_entry_t act, exp;
      do_reset();
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_3042;
      step(fired, act);
      bus.redirect_valid = 1'b0;
      exp_q.delete();
      exp_q.push_back(exp_entry(32'h3042));
      step(fired, act);
      step(fired, act);
      n_cmp++;
      sb_pop(exp, ok);
      if (!fired || !ok || act !== exp) begin
         n_bad++;
         $display("FAIL misaligned_entry: got fired=%b pc=%h instr=%h exc=%b, want pc=%h instr=%h exc=%b",
                  fired, act.pc, act.instr, act.exc, exp.pc, exp.instr, exp.exc);
      end
      fires = 0;
      for (int i = 0; i < 10; i++) begin
         step(fired, act);
         if (fired) fires++;
      end
      n_cmp++;
      if (fires != 0 || bus.im_addr !== 32'h0000_3042) begin
         n_bad++;
         $display("FAIL halt_quiet: got %0d transfers im_addr=%h, want 0 transfers im_addr=00003042",
                  fires, bus.im_addr);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_3000;
      step(fired, act);
      bus.redirect_valid = 1'b0;
      exp_q.push_back(exp_entry(32'h3000));
      exp_q.push_back(exp_entry(32'h3004));
      step(fired, act);
      for (int i = 0; i < 2; i++) begin
         step(fired, act);
         n_cmp++;
         sb_pop(exp, ok);
         if (!fired || !ok || act !== exp) begin
            n_bad++;
            $display("FAIL halt_resume: got fired=%b pc=%h, want fired=1 pc=%h", fired, act.pc, exp.pc);
         end
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_upper_bound();
      bit fired, ok;
      int fires;
      fetch_entry_t act, exp;
      do_reset();
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_6FFC;
      step(fired, act);
      bus.redirect_valid = 1'b0;
      exp_q.delete();
      exp_q.push_back(exp_entry(32'h6FFC));
      exp_q.push_back(exp_entry(32'h7000));
      step(fired, act);
      for (int i = 0; i < 2; i++) begin
         step(fired, act);
         n_cmp++;
         sb_pop(exp, ok);
         if (!fired || !ok || act !== exp) begin
            n_bad++;
            $display("FAIL upper_bound: got fired=%b pc=%h instr=%h exc=%b, want pc=%h instr=%h exc=%b",
                     fired, act.pc, act.instr, act.exc, exp.pc, exp.instr, exp.exc);
         end
      end
      fires = 0;
      for (int i = 0; i < 4; i++) begin
         step(fired, act);
         if (fired) fires++;
      end
      n_cmp++;
      if (fires != 0) begin
         n_bad++;
         $display("FAIL upper_halt: got %0d transfers, want 0", fires);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_2FFC;
      step(fired, act);
      bus.redirect_valid = 1'b0;
      exp_q.push_back(exp_entry(32'h2FFC));
      step(fired, act);
      step(fired, act);
      n_cmp++;
      sb_pop(exp, ok);
      if (!fired || !ok || act !== exp) begin
         n_bad++;
         $display("FAIL lower_bound: got fired=%b pc=%h instr=%h exc=%b, want pc=%h instr=%h exc=%b",
                  fired, act.pc, act.instr, act.exc, exp.pc, exp.instr, exp.exc);
      end
      fires = 0;
      for (int i = 0; i < 3; i++) begin
         step(fired, act);
         if (fired) fires++;
      end
      n_cmp++;
      if (fires != 0) begin
         n_bad++;
         $display("FAIL lower_halt: got %0d transfers, want 0", fires);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_override();
      bit fired, ok;
      fetch_entry_t act, exp;
      do_reset();
      for (int i = 0; i < 3; i++) step(fired, act);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_3000) begin
         n_bad++;
         $display("FAIL override_setup: got valid=%b pc=%h, want valid=1 pc=00003000",
                  bus.out_valid, bus.out_pc);
      end
      reset = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_3040;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'd0 || bus.out_instr !== 32'd0 || bus.out_exc !== 1'b0) begin
         n_bad++;
         $display("FAIL async_clear: got valid=%b pc=%h instr=%h exc=%b, want all zero",
                  bus.out_valid, bus.out_pc, bus.out_instr, bus.out_exc);
      end
      n_cmp++;
      if (bus.im_addr !== 32'h0000_3000) begin
         n_bad++;
         $display("FAIL async_pc: got %h want 00003000", bus.im_addr);
      end
      step(fired, act);
      reset = 1'b0;
      bus.redirect_valid = 1'b0;
      exp_q.delete();
      exp_q.push_back(exp_entry(32'h3000));
      exp_q.push_back(exp_entry(32'h3004));
      bus.out_ready = 1'b1;
      step(fired, act);
      for (int i = 0; i < 2; i++) begin
         step(fired, act);
         n_cmp++;
         sb_pop(exp, ok);
         if (!fired || !ok || act !== exp) begin
            n_bad++;
            $display("FAIL override_restart: got fired=%b pc=%h, want fired=1 pc=%h", fired, act.pc, exp.pc);
         end
      end
      bus.out_ready = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      @(negedge clk);
      test_reset();
      test_backpressure();
      test_redirect_flush();
      test_misaligned();
      test_upper_bound();
      test_reset_override();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
